// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length output levels. Events that
// arrive while a level is active are queued and replayed, each after a low gap.
module pulse_stretcher #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned MAX_PENDING = 3,
    parameter int unsigned RETRIGGER   = 0,
    localparam int unsigned PW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          pulse,
    input  logic          clear,
    output logic          level,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int unsigned CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [PW-1:0]   pend_d;
    logic            ovf_d;
    logic            pend_full;
    logic [PW-1:0]   pend_inc;
    logic [PW-1:0]   pend_dec;

    assign pend_full = (pending == PEND_MAX);
    assign pend_inc  = PW'(pending + 1'b1);
    assign pend_dec  = (pending != '0) ? PW'(pending - 1'b1) : '0;

    // Next-state, shared counter and pending-queue update; clear overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pending;
        ovf_d   = 1'b0;

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pend_d = '0;
                    if (pulse) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end

                HOLD: begin
                    if (pulse && (RETRIGGER != 0)) begin
                        cnt_d = HOLD_LOAD;
                    end else begin
                        if (pulse) begin
                            if (pend_full) ovf_d  = 1'b1;
                            else           pend_d = pend_inc;
                        end
                        // Queue decision sees an event captured on this same final cycle.
                        if (cnt_q == '0) begin
                            if (pend_d != '0) begin
                                state_d = GAP;
                                cnt_d   = GAP_LOAD;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            cnt_d = CW'(cnt_q - 1'b1);
                        end
                    end
                end

                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                        // A coincident event replaces the one being consumed.
                        if (!pulse) pend_d = pend_dec;
                    end else begin
                        cnt_d = CW'(cnt_q - 1'b1);
                        if (pulse) begin
                            if (pend_full) ovf_d  = 1'b1;
                            else           pend_d = pend_inc;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pend_d  = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            level    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pending  <= pend_d;
            overflow <= ovf_d;
            level    <= (state_d == HOLD);
            busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: per-cycle expected waveforms are hand-written
// strings (one character per cycle), for a queued instance and a retrigger instance.
module tb_pulse_stretcher;

    logic       clk;
    logic       resetN;
    logic       pulse;
    logic       clear;
    logic       level0, busy0, overflow0;
    logic [1:0] pending0;
    logic       level1, busy1, overflow1;
    logic [1:0] pending1;

    int checks   = 0;
    int failures = 0;

    pulse_stretcher dut0 (
        .clk      (clk),
        .resetN   (resetN),
        .pulse    (pulse),
        .clear    (clear),
        .level    (level0),
        .busy     (busy0),
        .pending  (pending0),
        .overflow (overflow0)
    );

    pulse_stretcher #(.RETRIGGER(1)) dut1 (
        .clk      (clk),
        .resetN   (resetN),
        .pulse    (pulse),
        .clear    (clear),
        .level    (level1),
        .busy     (busy1),
        .pending  (pending1),
        .overflow (overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int digit(input string s, input int k);
        if (k >= s.len()) return 0;
        return int'(s.getc(k)) - 48;
    endfunction

    task automatic check_outs(input bit sel, input string tag,
                              input int lv, input int by, input int pd, input int ov);
        int g_lv, g_by, g_pd, g_ov;
        g_lv = sel ? int'(level1)    : int'(level0);
        g_by = sel ? int'(busy1)     : int'(busy0);
        g_pd = sel ? int'(pending1)  : int'(pending0);
        g_ov = sel ? int'(overflow1) : int'(overflow0);
        check({tag, " level"},    g_lv, lv);
        check({tag, " busy"},     g_by, by);
        check({tag, " pending"},  g_pd, pd);
        check({tag, " overflow"}, g_ov, ov);
    endtask

    task automatic apply_reset(input bit sel, input string tag);
        resetN = 1'b0;
        pulse  = 1'b0;
        clear  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs(sel, {tag, " in reset"}, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Cycle k starts at a rising edge; inputs are driven just after it and outputs
    // checked on the falling edge, so a pulse in cycle k shows on outputs in k+1.
    task automatic run(input bit sel, input bit do_reset, input string tag,
                       input string pul, input string clr, input string lv,
                       input string by, input string pd, input string ov);
        if (do_reset) apply_reset(sel, tag);
        for (int k = 0; k < lv.len(); k++) begin
            @(posedge clk);
            #1;
            pulse = (digit(pul, k) == 1);
            clear = (digit(clr, k) == 1);
            @(negedge clk);
            check_outs(sel, $sformatf("%s c%0d", tag, k),
                       digit(lv, k), digit(by, k), digit(pd, k), digit(ov, k));
        end
        pulse = 1'b0;
        clear = 1'b0;
    endtask

    localparam string Z36 = "000000000000000000000000000000000000";

    initial begin
        resetN = 1'b0;
        pulse  = 1'b0;
        clear  = 1'b0;

        // Single pulse: four-cycle level, no queueing.
        run(1'b0, 1'b1, "single",
            "000000000010000000000000000000000000", Z36,
            "000000000001111000000000000000000000",
            "000000000001111000000000000000000000",
            Z36, Z36);

        // Two queued events replayed after low gaps.
        run(1'b0, 1'b1, "queued",
            "000000000010110000000000000000000000", Z36,
            "000000000001111001111001111000000000",
            "000000000001111111111111111000000000",
            "000000000000012221111110000000000000",
            Z36);

        // Back-to-back events saturate the queue; fifth one is dropped.
        run(1'b0, 1'b1, "saturate",
            "000000000011111000000000000000000000", Z36,
            "000000000001111001111001111001111000",
            "000000000001111111111111111111111000",
            "000000000000123332222221111110000000",
            "000000000000000100000000000000000000");

        // Retrigger instance: hold extends, including a pulse on the final cycle.
        run(1'b1, 1'b1, "retrig",
            "000000000010010001000000000000000000", Z36,
            "000000000001111111111100000000000000",
            "000000000001111111111100000000000000",
            Z36, Z36);

        // Clear during GAP with a coincident pulse: no replay, pulse not counted.
        run(1'b0, 1'b1, "clear",
            "000000000010100100000000000000000000",
            "000000000000000100000000000000000000",
            "000000000001111000000000000000000000",
            "000000000001111100000000000000000000",
            "000000000000011100000000000000000000",
            Z36);

        // Async reset mid-HOLD with two events queued.
        run(1'b0, 1'b1, "prereset",
            "00000000001110", "00000000000000",
            "00000000000111", "00000000000111",
            "00000000000012", "00000000000000");
        #2;
        resetN = 1'b0;
        #1;
        check_outs(1'b0, "async reset", 0, 0, 0, 0);
        #1;
        resetN = 1'b1;
        run(1'b0, 1'b0, "after reset",
            "0010000000", "0000000000",
            "0001111000", "0001111000",
            "0000000000", "0000000000");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event pulses (from rising-edge detectors on keys and collision flags) into sustained levels of programmable length. It queues events that arrive while a level is active and replays each one as its own stretched level, separated by a low gap. It sits between event sources and level-consuming logic such as sound enables, flash and blink effects, and score animations.

## Interface
- HOLD_CYCLES, default 4: length of each output level, in clock cycles; must be ≥1.
- GAP_CYCLES, default 2: forced low time between queued levels; must be ≥1.
- MAX_PENDING, default 3: saturation limit of the pending-event counter; must be ≥1.
- RETRIGGER, default 0: 1 means an event during HOLD restarts the hold count; 0 means the event is queued.
- clk  input  1  system clock; all logic on its rising edge.
- resetN  input  1  asynchronous active-low reset.
- pulse  input  1  event input; every clock cycle it is sampled high counts as one event.
- clear  input  1  synchronous abort; takes priority over pulse.
- level  output  1  stretched output level (registered).
- busy  output  1  high whenever state ≠ IDLE (registered).
- pending  output  PW  queued event count, where PW = $clog2(MAX_PENDING+1).
- overflow  output  1  one-cycle flag marking a dropped event.

## Operation
- States: IDLE, HOLD, GAP. One down-counter shared by HOLD and GAP. Separate pending counter.
- Reset (resetN low, asynchronous): state = IDLE, counters = 0, level = 0, busy = 0, pending = 0, overflow = 0.
- IDLE:
  - pulse → HOLD, load counter with HOLD_CYCLES−1.
  - Otherwise stay in IDLE. pending is always 0 in IDLE.
- HOLD, level = 1:
  - Counter decrements each cycle.
  - pulse with RETRIGGER=1: reload counter to HOLD_CYCLES−1; pending unchanged.
  - pulse with RETRIGGER=0: pending+1.
  - At counter = 0 (after the pulse update above): if pending (including an event queued this same cycle) > 0 → GAP, load GAP_CYCLES−1; otherwise → IDLE.
  - A RETRIGGER=1 pulse on the final HOLD cycle reloads the counter and stays in HOLD; level does not drop.
- GAP, level = 0:
  - Counter decrements each cycle; pulse → pending+1.
  - At counter = 0: pending−1 and → HOLD, load HOLD_CYCLES−1.
  - A pulse on the same cycle as this decrement leaves pending unchanged.
- Saturation: a pulse that would increment pending while pending = MAX_PENDING, with no simultaneous decrement, is dropped. overflow = 1 on the following cycle only.
- clear (any state): next cycle state = IDLE, level = 0, busy = 0, pending = 0, overflow = 0. A pulse on the same cycle as clear is ignored.
- pending never wraps: it is clamped to 0..MAX_PENDING.

## Timing
- Pulse sampled at edge t (from IDLE) → level high for cycles t+1 … t+HOLD_CYCLES, exactly HOLD_CYCLES cycles.
- Queued replay: level low for exactly GAP_CYCLES cycles, then high for HOLD_CYCLES cycles.
- busy matches level except that it also stays high through GAP.
- All outputs are registered. There is no combinational path from pulse or clear to any output.
- resetN asserted mid-operation forces all outputs to 0 immediately. Operation resumes from IDLE on the first edge after release.

## Test plan
Defaults apply unless a scenario states otherwise.
- Single pulse at cycle 10 → level and busy high cycles 11–14, low from 15; pending stays 0; overflow stays 0.
- Pulses at 10, 12, 13 (RETRIGGER=0) → level high 11–14, low 15–16, high 17–20, low 21–22, high 23–26. pending reads 1 at 13, 2 at 14, 1 at 17, 0 at 23. busy low from 27.
- Pulses every cycle 10–14 (RETRIGGER=0) → pending reaches 3 at cycle 14; the pulse at 14 is dropped; overflow high in cycle 15 only. Three replays follow the first level.
- RETRIGGER=1, pulses at 10 and 13 → level continuously high 11–17, pending 0. A further pulse at 17 extends level high through cycle 21.
- clear asserted during GAP together with a pulse → next cycle level 0, busy 0, pending 0. No replay occurs and the same-cycle pulse is not counted.
- resetN driven low mid-HOLD with pending = 2 → level, busy, pending and overflow all 0 without waiting for a clock edge. After release, a pulse at cycle n gives level high n+1 … n+4.
